// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 convolution over one raster-order 8-bit frame
// per start pulse. Emits valid-region (unpadded) pixels on an AXI-Stream.
// Pipeline: S1 window/line-buffer shift, S2 multiply-accumulate, S3 clamp.
// Optional build macro: CONV_ABS_EN -- take |sum| before the clamp
// (edge-magnitude mode); otherwise negative sums clamp to 0.

// One tap of the kernel: unsigned pixel times signed 3-bit weight.
module conv3x3_tap (
  input  logic [7:0]         pix_i,
  input  logic [2:0]         w_i,
  output logic signed [11:0] prod_o
);
  // Zero-extend pixel, sign-extend weight, both to the product width.
  assign prod_o = $signed({4'b0000, pix_i}) * $signed({{9{w_i[2]}}, w_i});
endmodule

module conv3x3_stream #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        run,
  input  logic [26:0] filter_weights,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_err
);

  localparam int STAGES = 2;
  localparam int TAPS   = 9;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Captured kernel, w[k] with k = 3*row + col.
  logic [TAPS-1:0][2:0] wt_q;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // lb0 holds the previous line, lb1 the line before it.
  logic [7:0] lb0_q [IMG_W];
  logic [7:0] lb1_q [IMG_W];

  // Window indexed [row][col]; row 0 oldest line, col 2 newest column.
  logic [2:0][2:0][7:0] win_q, win_d;

  // Stage valid / last flags: [0] window, [1] sum, [STAGES] output register.
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] last_pipe;

  logic [TAPS-1:0][11:0] prod;
  logic signed [15:0]    sum_q, sum_d;
  logic signed [15:0]    mag;
  logic [7:0]            out_q, out_d;
  logic                  err_q;

  logic en;
  logic load;
  logic accept;
  logic pix_last;
  logic win_ok;

  // Whole pipeline advances unless a beat is stuck at the output.
  assign en       = !vld_pipe[STAGES] || m_axis_tready;
  assign accept   = s_axis_tready && s_axis_tvalid;
  assign pix_last = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept && pix_last) state_d = FLUSH;
      FLUSH:   if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: input ready gated by RUN and downstream space; weight load.
  always_comb begin
    s_axis_tready = 1'b0;
    load          = 1'b0;
    case (state_q)
      IDLE:    load = start;
      STREAM:  s_axis_tready = run && en;
      default: ;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (load) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Counters, weights and sticky framing error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      wt_q  <= '0;
      err_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (load) begin
        wt_q  <= filter_weights;
        err_q <= 1'b0;
      end else if (accept && (s_axis_tlast != pix_last)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Line buffers shift one line down at the current column; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= s_axis_tdata;
    end
  end

  // New window column is {two lines up, one line up, incoming pixel}.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_q[col_q];
      win_d[1][2] = lb0_q[col_q];
      win_d[2][2] = s_axis_tdata;
    end
  end

  // S1 window register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_q <= '0;
    else        win_q <= win_d;
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    conv3x3_tap u_tap (
      .pix_i  (win_q[k/3][k%3]),
      .w_i    (wt_q[k]),
      .prod_o (prod[k])
    );
  end

  // Adder tree over the nine sign-extended products.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_d = sum_d + $signed({{4{prod[k][11]}}, prod[k]});
    end
  end

  // Clamp to 0..255, optionally folding negatives to their magnitude first.
  always_comb begin
    mag = sum_q;
`ifdef CONV_ABS_EN
    if (sum_q < 16'sd0) mag = -sum_q;
`endif
    if (mag < 16'sd0)        out_d = 8'd0;
    else if (mag > 16'sd255) out_d = 8'd255;
    else                     out_d = mag[7:0];
  end

  // S2/S3 data registers and valid/last shift registers, held when en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      sum_q     <= '0;
      out_q     <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0],  accept && win_ok};
      last_pipe <= {last_pipe[STAGES-1:0], accept && pix_last};
      sum_q     <= sum_d;
      out_q     <= out_d;
    end
  end

  assign m_axis_tdata  = out_q;
  assign m_axis_tvalid = vld_pipe[STAGES];
  assign m_axis_tlast  = last_pipe[STAGES];
  assign frame_err     = err_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 4x4 frame.
module tb_conv3x3_stream;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [26:0] K_ID  = 27'h0001000;
  localparam logic [26:0] K_ONE = 27'h1249249;
  localparam logic [26:0] K_NEG = 27'h7FFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        run = 1'b0;
  logic [26:0] filter_weights = '0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        frame_err;

  int n_asserts = 0;
  int n_fails   = 0;
  int stall_cyc = 0;
  logic [7:0] neg_exp;

  logic [7:0] beat_q [$];
  logic       last_q [$];

  conv3x3_stream #(.IMG_W(W), .IMG_H(H)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .run            (run),
    .filter_weights (filter_weights),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  // Capture every completed output handshake.
  always @(posedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      beat_q.push_back(m_axis_tdata);
      last_q.push_back(m_axis_tlast);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int w;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    w = 0;
    @(negedge clk);
    while (!s_axis_tready && w < 50) begin
      w++;
      @(negedge clk);
    end
    stall_cyc += w;
    if (w >= 50) check("send_timeout", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic pulse_start(input logic [26:0] wt);
    filter_weights = wt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_d [4];
    int w;
    exp_d = '{e0, e1, e2, e3};
    w = 0;
    while (beat_q.size() < 4 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    check({tag, "_beat_count"}, 32'(beat_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (beat_q.size() > 0) begin
        check($sformatf("%s_data%0d", tag, i), 32'(beat_q[0]), 32'(exp_d[i]));
        check($sformatf("%s_last%0d", tag, i), 32'(last_q[0]), 32'(i == 3));
        void'(beat_q.pop_front());
        void'(last_q.pop_front());
      end
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_no_extra_beats"}, 32'(beat_q.size()), 32'd0);
    check({tag, "_idle_tready"}, 32'(s_axis_tready), 32'd0);
    beat_q.delete();
    last_q.delete();
  endtask

  initial begin
`ifdef CONV_ABS_EN
    neg_exp = 8'd90;
`else
    neg_exp = 8'd0;
`endif
    // Reset values.
    #2;
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
    check("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
    check("rst_frame_err", 32'(frame_err),    32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_no_tready", 32'(s_axis_tready), 32'd0);

    // Identity kernel; weights changed after start must not matter.
    pulse_start(K_ID);
    filter_weights = K_NEG;
    stall_cyc = 0;
    for (int p = 0; p < 10; p++) send(8'(p), 1'b0);
    send(8'd10, 1'b0);
    check("lat_edge0_tvalid", 32'(m_axis_tvalid), 32'd0);
    send(8'd11, 1'b0);
    check("lat_edge1_tvalid", 32'(m_axis_tvalid), 32'd0);
    send(8'd12, 1'b0);
    check("lat_edge2_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("lat_edge2_tdata",  32'(m_axis_tdata),  32'd5);
    for (int p = 13; p < 16; p++) send(8'(p), p == 15);
    check("id_no_stall", 32'(stall_cyc), 32'd0);
    expect_frame("id", 8'd5, 8'd6, 8'd9, 8'd10);
    check("id_frame_err", 32'(frame_err), 32'd0);

    // Saturation; a start pulse mid-frame is ignored.
    pulse_start(K_ONE);
    for (int p = 0; p < 16; p++) begin
      if (p == 6) begin
        filter_weights = K_ID;
        start = 1'b1;
      end
      send(8'd200, p == 15);
      start = 1'b0;
    end
    expect_frame("sat", 8'd255, 8'd255, 8'd255, 8'd255);

    // Negative kernel.
    pulse_start(K_NEG);
    for (int p = 0; p < 16; p++) send(8'd10, p == 15);
    expect_frame("neg", neg_exp, neg_exp, neg_exp, neg_exp);

    // Backpressure while beat 5 sits at the output.
    pulse_start(K_ID);
    for (int p = 0; p < 13; p++) send(8'(p), 1'b0);
    m_axis_tready = 1'b0;
    s_axis_tdata  = 8'd13;
    s_axis_tvalid = 1'b1;
    #1;
    check("bp_tready_now", 32'(s_axis_tready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_tdata_held%0d", i),  32'(m_axis_tdata),  32'd5);
      check($sformatf("bp_tvalid_held%0d", i), 32'(m_axis_tvalid), 32'd1);
      check($sformatf("bp_s_tready%0d", i),    32'(s_axis_tready), 32'd0);
    end
    m_axis_tready = 1'b1;
    for (int p = 13; p < 16; p++) send(8'(p), p == 15);
    expect_frame("bp", 8'd5, 8'd6, 8'd9, 8'd10);

    // Frame error: early tlast on pixel 9, none on pixel 15.
    pulse_start(K_ID);
    for (int p = 0; p < 9; p++) send(8'(p), 1'b0);
    check("ferr_before", 32'(frame_err), 32'd0);
    send(8'd9, 1'b1);
    check("ferr_at9", 32'(frame_err), 32'd1);
    for (int p = 10; p < 16; p++) send(8'(p), 1'b0);
    expect_frame("ferr", 8'd5, 8'd6, 8'd9, 8'd10);
    check("ferr_sticky", 32'(frame_err), 32'd1);
    pulse_start(K_ID);
    check("ferr_cleared", 32'(frame_err), 32'd0);

    // Reset mid-frame after pixel 7 (with an early tlast on pixel 3).
    for (int p = 0; p < 8; p++) send(8'(p), p == 3);
    check("mid_ferr_set", 32'(frame_err), 32'd1);
    check("mid_tready",   32'(s_axis_tready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_s_tready",  32'(s_axis_tready), 32'd0);
    check("mrst_m_tvalid",  32'(m_axis_tvalid), 32'd0);
    check("mrst_m_tlast",   32'(m_axis_tlast),  32'd0);
    check("mrst_m_tdata",   32'(m_axis_tdata),  32'd0);
    check("mrst_frame_err", 32'(frame_err),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_idle_tready", 32'(s_axis_tready), 32'd0);
    beat_q.delete();
    last_q.delete();
    pulse_start(K_ID);
    for (int p = 0; p < 16; p++) send(8'(p), p == 15);
    expect_frame("post_rst", 8'd5, 8'd6, 8'd9, 8'd10);
    check("post_rst_ferr", 32'(frame_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
